// File: rtl/ub_arb_pkg.sv
// Shared types for the block-RAM arbiter: FSM states, response-pipe entry
// and the requester-id width helper.
package ub_arb_pkg;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Sized for the largest supported requester count (8).
    localparam int MAX_ID_W = 3;

    typedef struct packed {
        logic                is_read;
        logic [MAX_ID_W-1:0] id;
    } rsp_entry_t;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ub_rr_pick.sv
// Combinational rotating priority encoder: first valid index at or after ptr,
// wrapping from N-1 back to 0.
module ub_rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] idx,
    output logic          any
);

    // Scan from farthest to nearest so the index closest to ptr wins.
    always_comb begin
        idx = {PW{1'b0}};
        any = |valid;
        for (int k = N - 1; k >= 0; k--) begin
            if (valid[(int'(ptr) + k) % N]) begin
                idx = PW'((int'(ptr) + k) % N);
            end else begin
                idx = idx;
            end
        end
    end

endmodule

// File: rtl/ub_mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among NUM_REQ requesters,
// with bounded locked bursts and id-tagged read responses.
module ub_mem_arbiter
    import ub_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int MEM_LAT   = 1,
    parameter int MAX_BURST = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int IDW = id_w(NUM_REQ);
    localparam int BCW = $clog2(MAX_BURST + 1);

    arb_state_t       state_r, state_nxt_s;
    logic [IDW-1:0]   ptr_r, ptr_nxt_s;
    logic [IDW-1:0]   owner_r, owner_nxt_s;
    logic [BCW-1:0]   beat_cnt_r, beat_cnt_nxt_s;
    logic [IDW-1:0]   pick_idx_s, gnt_idx_s;
    logic             pick_any_s, accept_s;
    rsp_entry_t       pipe_r [MEM_LAT];

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
        return (int'(v) >= NUM_REQ - 1) ? {IDW{1'b0}} : v + {{(IDW-1){1'b0}}, 1'b1};
    endfunction

    ub_rr_pick #(.N(NUM_REQ), .PW(IDW)) u_pick (
        .valid (req_valid),
        .ptr   (ptr_r),
        .idx   (pick_idx_s),
        .any   (pick_any_s)
    );

    // Grant selection and next-state logic; a lock drop ends the burst even when the owner is idle.
    always_comb begin
        state_nxt_s    = state_r;
        ptr_nxt_s      = ptr_r;
        owner_nxt_s    = owner_r;
        beat_cnt_nxt_s = beat_cnt_r;
        gnt_idx_s      = pick_idx_s;
        accept_s       = 1'b0;
        if (reset) begin
            accept_s = 1'b0;
        end else if (state_r == LOCKED) begin
            gnt_idx_s = owner_r;
            accept_s  = req_valid[owner_r];
        end else begin
            accept_s = pick_any_s;
        end
        case (state_r)
            ARB: begin
                if (accept_s && req_lock[gnt_idx_s] && (MAX_BURST > 1)) begin
                    state_nxt_s    = LOCKED;
                    owner_nxt_s    = gnt_idx_s;
                    beat_cnt_nxt_s = BCW'(1);
                end else if (accept_s) begin
                    ptr_nxt_s = wrap_inc(gnt_idx_s);
                end else begin
                    ptr_nxt_s = ptr_r;
                end
            end
            LOCKED: begin
                if (!req_lock[owner_r] || (accept_s && (beat_cnt_r == BCW'(MAX_BURST - 1)))) begin
                    state_nxt_s    = ARB;
                    ptr_nxt_s      = wrap_inc(owner_r);
                    beat_cnt_nxt_s = {BCW{1'b0}};
                end else if (accept_s) begin
                    beat_cnt_nxt_s = beat_cnt_r + BCW'(1);
                end else begin
                    beat_cnt_nxt_s = beat_cnt_r;
                end
            end
            default: begin
                state_nxt_s = ARB;
            end
        endcase
    end

    // Memory port and ready strobe follow the granted requester with no added latency.
    always_comb begin
        req_ready = {NUM_REQ{1'b0}};
        if (accept_s) begin
            req_ready[gnt_idx_s] = 1'b1;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
        mem_en    = accept_s;
        mem_we    = accept_s & req_we[gnt_idx_s];
        mem_addr  = req_addr[int'(gnt_idx_s)*ADDR_W +: ADDR_W];
        mem_wdata = req_wdata[int'(gnt_idx_s)*DATA_W +: DATA_W];
    end

    // Arbitration state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= ARB;
            ptr_r      <= {IDW{1'b0}};
            owner_r    <= {IDW{1'b0}};
            beat_cnt_r <= {BCW{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            ptr_r      <= ptr_nxt_s;
            owner_r    <= owner_nxt_s;
            beat_cnt_r <= beat_cnt_nxt_s;
        end
    end

    // Response tag pipe aligned with the RAM read latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                pipe_r[i] <= '{is_read: 1'b0, id: {MAX_ID_W{1'b0}}};
            end
        end else begin
            pipe_r[0] <= '{is_read: accept_s & ~req_we[gnt_idx_s], id: MAX_ID_W'(gnt_idx_s)};
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    // Decode the pipe tail into per-requester response strobes.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = pipe_r[MEM_LAT-1].is_read && (pipe_r[MEM_LAT-1].id == MAX_ID_W'(i));
        end
        rsp_rdata = mem_rdata;
    end

endmodule

// File: tb/tb_ub_mem_arbiter.sv
// Directed self-checking bench for ub_mem_arbiter (2 requesters, 1-cycle RAM,
// burst cap 4) with a behavioural RAM preloaded to mem[a] = a + 0x1000.
module tb_ub_mem_arbiter;

    logic        clock;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_lock;
    logic [1:0]  req_we;
    logic [23:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] ram [4096];
    int checks;
    int errors;

    ub_mem_arbiter #(
        .NUM_REQ(2), .ADDR_W(12), .DATA_W(32), .MEM_LAT(1), .MAX_BURST(4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_lock  (req_lock),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single-port RAM model, one-cycle read latency.
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 2'b00;
        req_lock  = 2'b00;
        req_we    = 2'b00;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 2'b11;
        req_we    = 2'b01;
        @(negedge clock);
        checks++;
        if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || mem_en !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b rsp=%b en=%b we=%b, required 00 00 0 0",
                     req_ready, rsp_valid, mem_en, mem_we);
        end
        do_reset();
    endtask

    task automatic test_single_read();
        req_valid = 2'b01;
        req_we    = 2'b00;
        req_addr[11:0] = 12'h010;
        @(negedge clock);
        checks++;
        if (req_ready !== 2'b01 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'h010) begin
            errors++;
            $display("FAIL single_read_grant: ready=%b en=%b we=%b addr=%h, required 01 1 0 010",
                     req_ready, mem_en, mem_we, mem_addr);
        end
        next_cycle();
        req_valid = 2'b00;
        @(negedge clock);
        checks++;
        if (rsp_valid !== 2'b01 || rsp_rdata !== 32'h0000_1010) begin
            errors++;
            $display("FAIL single_read_rsp: rsp=%b data=%h, required 01 00001010", rsp_valid, rsp_rdata);
        end
        next_cycle();
    endtask

    task automatic test_contention();
        logic [1:0]  exp_rdy [4];
        logic [31:0] exp_dat [4];
        exp_rdy[0] = 2'b01; exp_rdy[1] = 2'b10; exp_rdy[2] = 2'b01; exp_rdy[3] = 2'b10;
        exp_dat[0] = 32'h0000_1001; exp_dat[1] = 32'h0000_1002;
        exp_dat[2] = 32'h0000_1001; exp_dat[3] = 32'h0000_1002;
        do_reset();
        req_valid = 2'b11;
        req_we    = 2'b00;
        req_addr  = {12'h002, 12'h001};
        for (int k = 0; k <= 4; k++) begin
            if (k == 4) req_valid = 2'b00;
            @(negedge clock);
            if (k < 4) begin
                checks++;
                if (req_ready !== exp_rdy[k]) begin
                    errors++;
                    $display("FAIL contention_grant%0d: ready=%b, required %b", k, req_ready, exp_rdy[k]);
                end
            end
            if (k > 0) begin
                checks++;
                if (rsp_valid !== exp_rdy[k-1] || rsp_rdata !== exp_dat[k-1]) begin
                    errors++;
                    $display("FAIL contention_rsp%0d: rsp=%b data=%h, required %b %h",
                             k - 1, rsp_valid, rsp_rdata, exp_rdy[k-1], exp_dat[k-1]);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_write_then_read();
        req_valid = 2'b10;
        req_we    = 2'b10;
        req_addr[23:12]  = 12'h100;
        req_wdata[63:32] = 32'hDEAD_BEEF;
        @(negedge clock);
        checks++;
        if (req_ready !== 2'b10 || mem_we !== 1'b1 || mem_addr !== 12'h100 || mem_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_beat: ready=%b we=%b addr=%h wdata=%h, required 10 1 100 deadbeef",
                     req_ready, mem_we, mem_addr, mem_wdata);
        end
        next_cycle();
        req_we = 2'b00;
        @(negedge clock);
        checks++;
        if (rsp_valid !== 2'b00 || req_ready !== 2'b10 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL read_after_write: rsp=%b ready=%b we=%b, required 00 10 0",
                     rsp_valid, req_ready, mem_we);
        end
        next_cycle();
        req_valid = 2'b00;
        @(negedge clock);
        checks++;
        if (rsp_valid !== 2'b10 || rsp_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL readback: rsp=%b data=%h, required 10 deadbeef", rsp_valid, rsp_rdata);
        end
        next_cycle();
    endtask

    task automatic test_burst_cap();
        logic [1:0] exp_rdy [6];
        exp_rdy[0] = 2'b01; exp_rdy[1] = 2'b01; exp_rdy[2] = 2'b01;
        exp_rdy[3] = 2'b01; exp_rdy[4] = 2'b10; exp_rdy[5] = 2'b01;
        do_reset();
        req_valid = 2'b11;
        req_lock  = 2'b01;
        req_we    = 2'b00;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            checks++;
            if (req_ready !== exp_rdy[k]) begin
                errors++;
                $display("FAIL burst_beat%0d: ready=%b, required %b", k, req_ready, exp_rdy[k]);
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_early_unlock();
        do_reset();
        req_valid = 2'b11;
        req_lock  = 2'b01;
        @(negedge clock);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL lock_start: ready=%b, required 01", req_ready);
        end
        next_cycle();
        req_valid = 2'b10;
        @(negedge clock);
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL lock_owner_idle: ready=%b, required 00", req_ready);
        end
        next_cycle();
        req_valid = 2'b11;
        req_lock  = 2'b00;
        @(negedge clock);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL unlock_last_beat: ready=%b, required 01", req_ready);
        end
        next_cycle();
        @(negedge clock);
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL after_unlock: ready=%b, required 10", req_ready);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        req_valid = 2'b01;
        req_we    = 2'b00;
        req_addr[11:0] = 12'h005;
        @(negedge clock);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL midreset_accept: ready=%b, required 01", req_ready);
        end
        reset     = 1'b1;
        req_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            @(negedge clock);
            checks++;
            if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
                errors++;
                $display("FAIL midreset_quiet%0d: rsp=%b ready=%b, required 00 00", k, rsp_valid, req_ready);
            end
        end
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (req_ready !== 2'b01 || rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL midreset_first_grant: ready=%b rsp=%b, required 01 00", req_ready, rsp_valid);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        req_valid = 2'b00;
        req_lock  = 2'b00;
        req_we    = 2'b00;
        req_addr  = 24'h000000;
        req_wdata = 64'h0;
        mem_rdata = 32'h0;
        for (int a = 0; a < 4096; a++) ram[a] = 32'h1000 + 32'(a);
        test_reset();
        test_single_read();
        test_contention();
        test_write_then_read();
        test_burst_cap();
        test_early_unlock();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ub_mem_arbiter.md
Name: ub_mem_arbiter

Overview:
- Round-robin arbiter that shares one single-port block RAM among NUM_REQ requesters.
- Typical requesters are the MicroBlaze LMB/AXI-lite bridge and the video/game-logic engines of the main_ub design.
- Grants at most one access per cycle and supports locked bursts of bounded length.
- Tags reads so that read data returns to the issuing requester after the fixed RAM latency.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 12, RAM word-address width
DATA_W, 32, RAM data width
MEM_LAT, 1, RAM read latency in cycles (1..3)
MAX_BURST, 4, maximum beats accepted under one lock before forced rotation (>=1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester access request
req_lock  in  NUM_REQ  requester asks to keep the grant for following beats
req_we  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
req_ready  out  NUM_REQ  one-hot-or-zero accept strobe
rsp_valid  out  NUM_REQ  read data valid for requester i
rsp_rdata  out  DATA_W  shared read data bus (mem_rdata passthrough)
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid MEM_LAT cycles after mem_en

Behaviour:
- Reset is asynchronous and active-high. While reset is high:
  - state=ARB, ptr=0, owner=0, beat_cnt=0, response pipe cleared.
  - req_ready, rsp_valid, mem_en and mem_we are all 0.
- Handshake:
  - Transfer occurs when req_valid[i] & req_ready[i].
  - req_ready is combinational from req_valid and state; at most one bit is set per cycle.
  - Requesters must hold addr/we/wdata stable until accepted.
- Memory port is combinational from the granted requester:
  - mem_en = accept, mem_we = accept & req_we[g].
  - mem_addr and mem_wdata are muxed from g.
  - Zero added request latency.
- ARB state:
  - g = first i with req_valid[i], scanning ptr, ptr+1, ... wrapping N-1 -> 0.
  - req_ready[g] = 1. No valid requester -> no grant, ptr unchanged.
- On accept in ARB with req_lock[g]=0, or with MAX_BURST=1: ptr <= (g+1) mod NUM_REQ; stay in ARB.
- On accept in ARB with req_lock[g]=1 and MAX_BURST>1: state <= LOCKED, owner <= g, beat_cnt <= 1.
- LOCKED state:
  - Only owner may be granted: req_ready[owner] = req_valid[owner]. Others wait even if owner is idle.
  - On each owner accept, beat_cnt increments.
  - Exit to ARB with ptr <= owner+1 when either:
    - req_lock[owner]=0 in any cycle; that cycle's beat is still granted and is the last, or
    - an accepted beat brings beat_cnt to MAX_BURST.
  - A new lock cannot start in the exit cycle.
- Read responses:
  - Shift pipe of depth MEM_LAT carries {is_read, id}.
  - rsp_valid[id] = 1 exactly MEM_LAT cycles after a read accept.
  - Writes produce no response.
  - Back-to-back reads from different requesters return in issue order, one per cycle.
- Reset mid-operation: in-flight responses are dropped (rsp_valid stays 0), locks are released, ptr returns to 0.
- Simultaneous valid from all requesters yields fair rotation: each is granted once per NUM_REQ accepts when no locks are active.

Decomposition:
- Package ub_arb_pkg holds:
  - state enum {ARB, LOCKED}
  - ID_W = clog2(NUM_REQ) helper function
  - response-pipe entry struct {is_read, id}
- One natural sub-module: ub_rr_pick, a combinational rotating priority encoder (inputs valid vector and ptr; outputs grant index and any-grant flag).

Test Plan (NUM_REQ=2, ADDR_W=12, DATA_W=32, MEM_LAT=1, MAX_BURST=4; RAM model preloaded with mem[a]=a+0x1000):
- Single read: req0 read addr 0x010 -> req_ready[0] same cycle, mem_en=1, mem_addr=0x010; next cycle rsp_valid=2'b01, rsp_rdata=0x1010.
- Contention: both valid reads (req0 0x001, req1 0x002) held for 4 cycles, no lock -> grants 0,1,0,1; rsp_valid 01,10,01,10 one cycle delayed with data 0x1001/0x1002.
- Write then read: req1 writes 0xDEADBEEF to 0x100, then reads 0x100 -> mem_we=1 on first beat, no rsp on the write; read returns 0xDEADBEEF with rsp_valid=2'b10.
- Burst cap: req0 lock=1, valid for 6 beats while req1 valid -> req0 gets 4 consecutive grants, req1 granted on beat 5, req0 resumes after.
- Early unlock: req0 locks, drops req_lock on 2nd beat, req1 waiting -> 2nd beat granted to req0, req1 granted next cycle.
- Reset mid-read: assert reset in the cycle after a read accept -> rsp_valid never asserts; after release, first grant goes to req0 when both requesters are valid.
